id_exe_stage_buf: RTL and testbench



---
 rtl/id_exe_pkg.sv | 45 ++++
 rtl/id_exe_payload_slot.sv | 49 ++++
 rtl/id_exe_stage_buf.sv | 189 ++++++++++++++++++
 tb/tb_id_exe_stage_buf.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_pkg
// Description : Shared constants for the ID->EXE pipeline boundary.
//               Control-bit indices, FSM state encodings, payload field
//               widths and the slot positions inside the packed
//               regs/imm/data buses.
// Revision    : 1.0 - initial release
// ============================================================================
package id_exe_pkg;

    // Bit positions inside the 7-bit control word
    localparam int CTRL_WB     = 0;
    localparam int CTRL_MEM_R  = 1;
    localparam int CTRL_MEM_W  = 2;
    localparam int CTRL_B      = 3;
    localparam int CTRL_S      = 4;
    localparam int CTRL_I      = 5;
    localparam int CTRL_STATUS = 6;
    localparam int CTRL_W      = 7;

    localparam int EXE_CMD_W   = 4;

    // Immediate bus: {imm24, shift_operand}
    localparam int IMM_W        = 36;
    localparam int SHIFT_OP_LSB = 0;
    localparam int SHIFT_OP_W   = 12;
    localparam int IMM24_LSB    = 12;
    localparam int IMM24_W      = 24;

    // Slot numbers in the packed buses; a field starts at slot*width
    localparam int REG_DEST_SLOT = 0;
    localparam int REG_SRC1_SLOT = 1;
    localparam int REG_SRC2_SLOT = 2;
    localparam int DATA_PC_SLOT  = 0;
    localparam int DATA_RM_SLOT  = 1;
    localparam int DATA_RN_SLOT  = 2;

    // Buffer state: number of beats held
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/id_exe_payload_slot.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_payload_slot
// Description : One payload register with a valid flag.
//               load  : capture d and mark the slot valid
//               clear : drop the valid flag (wins over load)
//               Ports : clk, rst (async, active-high), load, clear, d,
//                       valid, q
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_payload_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
        end
    end

    // Data may capture even on a clear cycle; it is stale but never valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= d;
        end
    end

    assign valid = r_valid;
    assign q     = r_data;

endmodule
`default_nettype wire

// File: rtl/id_exe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_stage_buf
// Description : ID->EXE pipeline boundary with valid/ready handshake and a
//               2-entry skid buffer (main slot drives outputs, skid slot
//               absorbs one beat of backpressure). Synchronous flush,
//               asynchronous active-high reset. in_ready depends on
//               registered state only.
//               Upstream  : in_valid/in_ready, in_ctrl, in_exe_cmd, in_regs,
//                           in_imm, in_data, flush
//               Downstream: out_valid/out_ready, out_ctrl (gated by valid),
//                           out_exe_cmd, out_regs, out_imm, out_data
//               Status    : occupancy (0..2)
//               Option    : `define ID_EXE_PERF_EN adds saturating
//                           stall_cnt / flush_cnt outputs (width CNT_W).
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_stage_buf
    import id_exe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
`ifdef ID_EXE_PERF_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [EXE_CMD_W-1:0]  in_exe_cmd,
    input  logic [3*REG_AW-1:0]   in_regs,
    input  logic [IMM_W-1:0]      in_imm,
    input  logic [3*DATA_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [EXE_CMD_W-1:0]  out_exe_cmd,
    output logic [3*REG_AW-1:0]   out_regs,
    output logic [IMM_W-1:0]      out_imm,
    output logic [3*DATA_W-1:0]   out_data,
    output logic [1:0]            occupancy
`ifdef ID_EXE_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int PAY_W = CTRL_W + EXE_CMD_W + 3*REG_AW + IMM_W + 3*DATA_W;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_drain;
    logic             w_main_load;
    logic             w_main_from_skid;
    logic             w_main_clear;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic             w_main_valid;
    logic             w_skid_valid;
    logic [PAY_W-1:0] w_in_pay;
    logic [PAY_W-1:0] w_main_d;
    logic [PAY_W-1:0] w_main_q;
    logic [PAY_W-1:0] w_skid_q;
    logic [CTRL_W-1:0] w_main_ctrl;

    assign w_in_pay = {in_ctrl, in_exe_cmd, in_regs, in_imm, in_data};

    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = w_main_valid & out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_drain)      w_state_nxt = ST_FULL;
                    else if (!w_accept && w_drain) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_drain) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot control strobes; flush rides on the slot clear, which wins.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = flush;
        w_skid_load      = 1'b0;
        w_skid_clear     = flush;
        case (r_state)
            ST_EMPTY: w_main_load = w_accept;
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_main_load = 1'b1;
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                end else if (w_drain) begin
                    w_main_clear = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                end
            end
            default: begin
                w_main_clear = 1'b1;
                w_skid_clear = 1'b1;
            end
        endcase
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_pay;

    id_exe_payload_slot #(.W(PAY_W)) u_main_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (w_main_load),
        .clear (w_main_clear),
        .d     (w_main_d),
        .valid (w_main_valid),
        .q     (w_main_q)
    );

    id_exe_payload_slot #(.W(PAY_W)) u_skid_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_in_pay),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

    assign {w_main_ctrl, out_exe_cmd, out_regs, out_imm, out_data} = w_main_q;

    // Bubbles must never write back or touch memory.
    assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`ifdef ID_EXE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && (occupancy != 2'd0) && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_stage_buf
// Description : Self-checking bench for id_exe_stage_buf. A table of
//               per-cycle vectors with hand-derived expected outputs, plus
//               hand-written sequences for async reset and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_buf;
    import id_exe_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;
    localparam int PAY_CHK_W = EXE_CMD_W + 3*REG_AW + IMM_W + 3*DATA_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [EXE_CMD_W-1:0] in_exe_cmd;
    logic [3*REG_AW-1:0]  in_regs;
    logic [IMM_W-1:0]     in_imm;
    logic [3*DATA_W-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [EXE_CMD_W-1:0] out_exe_cmd;
    logic [3*REG_AW-1:0]  out_regs;
    logic [IMM_W-1:0]     out_imm;
    logic [3*DATA_W-1:0]  out_data;
    logic [1:0]           occupancy;
`ifdef ID_EXE_PERF_EN
    logic [3:0]           stall_cnt;
    logic [3:0]           flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_exe_stage_buf #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
`ifdef ID_EXE_PERF_EN
        ,
        .CNT_W  (4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_exe_cmd  (in_exe_cmd),
        .in_regs     (in_regs),
        .in_imm      (in_imm),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_exe_cmd (out_exe_cmd),
        .out_regs    (out_regs),
        .out_imm     (out_imm),
        .out_data    (out_data),
        .occupancy   (occupancy)
`ifdef ID_EXE_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    // Every beat's non-ctrl payload is derived from its pc, so the pc alone
    // identifies which beat is on the output.
    function automatic logic [PAY_CHK_W-1:0] pay_of(input logic [31:0] pc);
        logic [23:0] imm24;
        imm24 = pc[23:0] ^ 24'hABCDEF;
        return {pc[5:2], pc[11:0], imm24, pc[11:0], ~pc, pc ^ 32'hA5A5A5A5, pc};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] pc, input logic [6:0] ctrl);
        logic [PAY_CHK_W-1:0] p;
        p = pay_of(pc);
        flush     = fl;
        in_valid  = iv;
        out_ready = ordy;
        in_ctrl   = ctrl;
        {in_exe_cmd, in_regs, in_imm, in_data} = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fl, iv, ordy;
        logic [31:0] pc;
        logic [6:0]  ctrl;
        logic        e_ov, e_ir;
        logic [1:0]  e_occ;
        logic        e_chk;
        logic [31:0] e_pc;
        logic [6:0]  e_ctrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fl, iv, ordy, input logic [31:0] pc, input logic [6:0] ctrl,
                       input logic e_ov, e_ir, input logic [1:0] e_occ,
                       input logic e_chk, input logic [31:0] e_pc, input logic [6:0] e_ctrl);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.pc = pc; v.ctrl = ctrl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_occ = e_occ;
        v.e_chk = e_chk; v.e_pc = e_pc; v.e_ctrl = e_ctrl;
        vecs.push_back(v);
    endtask

    initial begin
        // Expected values are the outputs just after the clock edge on which
        // the vector's inputs are sampled.
        //   fl iv or pc         ctrl    ov ir occ chk e_pc       e_ctrl
        add(0, 1, 1, 32'h100, 7'h01,  1, 1, 1, 1, 32'h100, 7'h01);  // single beat
        add(0, 0, 1, 32'h0,   7'h00,  0, 1, 0, 0, 32'h0,   7'h00);  // drained
        add(0, 1, 0, 32'h10,  7'h03,  1, 1, 1, 1, 32'h10,  7'h03);  // backpressure
        add(0, 1, 0, 32'h14,  7'h05,  1, 0, 2, 1, 32'h10,  7'h03);  // into skid
        add(0, 1, 0, 32'h18,  7'h07,  1, 0, 2, 1, 32'h10,  7'h03);  // held upstream
        add(0, 1, 1, 32'h18,  7'h07,  1, 1, 1, 1, 32'h14,  7'h05);  // skid->main
        add(0, 1, 1, 32'h18,  7'h07,  1, 1, 1, 1, 32'h18,  7'h07);  // reload main
        add(0, 0, 1, 32'h0,   7'h00,  0, 1, 0, 0, 32'h0,   7'h00);
        for (int i = 0; i < 8; i++) begin                          // streaming
            add(0, 1, 1, 32'h20 + 32'(4*i), 7'(8+i), 1, 1, 1, 1, 32'h20 + 32'(4*i), 7'(8+i));
        end
        add(0, 1, 0, 32'h40,  7'h11,  1, 0, 2, 1, 32'h3C,  7'h0F);  // FULL
        add(1, 1, 0, 32'h44,  7'h12,  0, 1, 0, 0, 32'h0,   7'h00);  // flush FULL
        add(0, 1, 0, 32'h48,  7'h13,  1, 1, 1, 1, 32'h48,  7'h13);
        add(1, 1, 1, 32'h4C,  7'h14,  0, 1, 0, 0, 32'h0,   7'h00);  // flush + beat
        add(0, 0, 1, 32'h0,   7'h00,  0, 1, 0, 0, 32'h0,   7'h00);  // 4C never shows
        add(0, 1, 1, 32'h50,  7'h15,  1, 1, 1, 1, 32'h50,  7'h15);
        add(0, 0, 1, 32'h0,   7'h00,  0, 1, 0, 0, 32'h0,   7'h00);

        // Reset state
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 7'h00);
        tick();
        tick();
        check("reset out_valid", 160'(out_valid), 160'(1'b0));
        check("reset in_ready",  160'(in_ready),  160'(1'b1));
        check("reset occupancy", 160'(occupancy), 160'(2'd0));
        check("reset out_ctrl",  160'(out_ctrl),  160'(7'h00));
        check("reset payload",   160'({out_exe_cmd, out_regs, out_imm, out_data}), 160'(0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].fl, vecs[k].iv, vecs[k].ordy, vecs[k].pc, vecs[k].ctrl);
            tick();
            check($sformatf("v%0d out_valid", k), 160'(out_valid), 160'(vecs[k].e_ov));
            check($sformatf("v%0d in_ready", k),  160'(in_ready),  160'(vecs[k].e_ir));
            check($sformatf("v%0d occupancy", k), 160'(occupancy), 160'(vecs[k].e_occ));
            check($sformatf("v%0d out_ctrl", k),  160'(out_ctrl),  160'(vecs[k].e_ctrl));
            if (vecs[k].e_chk) begin
                check($sformatf("v%0d payload", k),
                      160'({out_exe_cmd, out_regs, out_imm, out_data}), 160'(pay_of(vecs[k].e_pc)));
            end
        end

        // Async reset mid-cycle while FULL
        @(negedge clk);
        drive(0, 1, 0, 32'h100, 7'h21);
        tick();
        @(negedge clk);
        drive(0, 1, 0, 32'h104, 7'h22);
        tick();
        check("pre-reset occupancy", 160'(occupancy), 160'(2'd2));
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 160'(out_valid), 160'(1'b0));
        check("async rst occupancy", 160'(occupancy), 160'(2'd0));
        check("async rst in_ready",  160'(in_ready),  160'(1'b1));
        check("async rst out_ctrl",  160'(out_ctrl),  160'(7'h00));
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 1, 32'h200, 7'h23);
        tick();
        check("post-rst out_valid", 160'(out_valid), 160'(1'b1));
        check("post-rst payload", 160'({out_exe_cmd, out_regs, out_imm, out_data}), 160'(pay_of(32'h200)));
        check("post-rst out_ctrl", 160'(out_ctrl), 160'(7'h23));
        @(negedge clk);
        drive(0, 0, 1, 32'h0, 7'h00);
        tick();
        check("post-rst drain occupancy", 160'(occupancy), 160'(2'd0));

`ifdef ID_EXE_PERF_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("perf stall_cnt reset", 160'(stall_cnt), 160'(4'h0));
        check("perf flush_cnt reset", 160'(flush_cnt), 160'(4'h0));
        // Two beats fill the buffer, then 20 stalled cycles
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 32'h300 + 32'(4*i), 7'h01);
            tick();
        end
        check("perf stall_cnt saturated", 160'(stall_cnt), 160'(4'hF));
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 7'h00);           // flush with 2 beats
        tick();
        @(negedge clk);
        drive(1, 0, 0, 32'h0, 7'h00);           // flush while empty: not counted
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 32'h400, 7'h02);
            tick();
            @(negedge clk);
            drive(1, 0, 0, 32'h0, 7'h00);
            tick();
        end
        check("perf flush_cnt", 160'(flush_cnt), 160'(4'h3));
`endif

        @(negedge clk);
        drive(0, 0, 0, 32'h0, 7'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
